// File: rtl/spi_reg_ctrl.sv
// SPI frame controller: decodes command+data byte frames into single register
// accesses, shares the register port with a local requester (SPI first), and
// preloads the shifter's transmit byte with read data.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for the command byte of a frame
// S_RD_ACC  | read access on the register port this cycle
// S_RD_WAIT | read data returning; loaded into tx byte at end of cycle
// S_WR_DATA | write command latched, waiting for the data byte
// S_WR_ACC  | write access on the register port this cycle
// S_DONE    | frame served; extra bytes ignored until frame end
module spi_reg_ctrl #(
  parameter int unsigned ADDR_W    = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [7:0]        rx_byte_i,
  input  logic              rx_valid_i,
  input  logic              frame_end_i,
  output logic [7:0]        tx_byte_o,
  input  logic              loc_req_i,
  input  logic              loc_we_i,
  input  logic [ADDR_W-1:0] loc_addr_i,
  input  logic [7:0]        loc_wdata_i,
  output logic              loc_gnt_o,
  output logic [7:0]        loc_rdata_o,
  output logic              reg_en_o,
  output logic              reg_we_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [7:0]        reg_wdata_o,
  input  logic [7:0]        reg_rdata_i,
  output logic [7:0]        abort_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ACC,
    S_RD_WAIT,
    S_WR_DATA,
    S_WR_ACC,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        abort_q, abort_d;
  logic              loc_rd_pend_q, loc_rd_pend_d;
  logic [7:0]        loc_rdata_q, loc_rdata_d;

  logic spi_rd;
  logic spi_wr;
  logic loc_gnt;

  // State and frame-field registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      tx_q          <= SYNC_BYTE;
      abort_q       <= '0;
      loc_rd_pend_q <= 1'b0;
      loc_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      tx_q          <= tx_d;
      abort_q       <= abort_d;
      loc_rd_pend_q <= loc_rd_pend_d;
      loc_rdata_q   <= loc_rdata_d;
    end
  end

  // Frame sequencing; frame end overrides everything, including a same-cycle byte.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tx_d    = tx_q;
    abort_d = abort_q;
    if (frame_end_i) begin
      state_d = S_IDLE;
      tx_d    = SYNC_BYTE;
      // A frame counts as aborted only if it was cut before its access took effect.
      if ((state_q == S_WR_DATA || state_q == S_RD_ACC || state_q == S_RD_WAIT) &&
          abort_q != 8'hFF) begin
        abort_d = abort_q + 8'd1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_valid_i) begin
            addr_d  = rx_byte_i[ADDR_W-1:0];
            state_d = rx_byte_i[7] ? S_RD_ACC : S_WR_DATA;
          end
        end
        S_RD_ACC:  state_d = S_RD_WAIT;
        S_RD_WAIT: begin
          tx_d    = reg_rdata_i;
          state_d = S_DONE;
        end
        S_WR_DATA: begin
          if (rx_valid_i) begin
            wdata_d = rx_byte_i;
            state_d = S_WR_ACC;
          end
        end
        S_WR_ACC:  state_d = S_DONE;
        S_DONE:    state_d = S_DONE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Register port arbitration: SPI accesses never wait, local takes any other cycle.
  always_comb begin
    spi_rd      = (state_q == S_RD_ACC);
    spi_wr      = (state_q == S_WR_ACC);
    loc_gnt     = loc_req_i && !(spi_rd || spi_wr);
    reg_en_o    = spi_rd || spi_wr || loc_gnt;
    reg_we_o    = spi_wr || (loc_gnt && loc_we_i);
    reg_addr_o  = '0;
    reg_wdata_o = '0;
    if (spi_rd || spi_wr) begin
      reg_addr_o = addr_q;
    end else if (loc_gnt) begin
      reg_addr_o = loc_addr_i;
    end
    if (spi_wr) begin
      reg_wdata_o = wdata_q;
    end else if (loc_gnt && loc_we_i) begin
      reg_wdata_o = loc_wdata_i;
    end
  end

  // Local read return: pass data through on its valid cycle, then hold it.
  always_comb begin
    loc_rd_pend_d = loc_gnt && !loc_we_i;
    loc_rdata_d   = loc_rd_pend_q ? reg_rdata_i : loc_rdata_q;
  end

  assign loc_gnt_o   = loc_gnt;
  assign loc_rdata_o = loc_rd_pend_q ? reg_rdata_i : loc_rdata_q;
  assign tx_byte_o   = tx_q;
  assign abort_cnt_o = abort_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed frames with literal expectations, then
// randomized SPI frames and local requests against a cycle-count reference model.
module tb_spi_reg_ctrl;
  localparam int         AW   = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_byte = '0;
  logic          rx_valid = 1'b0;
  logic          frame_end = 1'b0;
  logic [7:0]    tx_byte;
  logic          loc_req = 1'b0;
  logic          loc_we = 1'b0;
  logic [AW-1:0] loc_addr = '0;
  logic [7:0]    loc_wdata = '0;
  logic          loc_gnt;
  logic [7:0]    loc_rdata;
  logic          reg_en;
  logic          reg_we;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic [7:0]    reg_rdata;
  logic [7:0]    abort_cnt;

  always #5 clk = ~clk;

  spi_reg_ctrl #(.ADDR_W(AW), .SYNC_BYTE(SYNC)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .rx_byte_i(rx_byte), .rx_valid_i(rx_valid), .frame_end_i(frame_end),
    .tx_byte_o(tx_byte),
    .loc_req_i(loc_req), .loc_we_i(loc_we), .loc_addr_i(loc_addr),
    .loc_wdata_i(loc_wdata), .loc_gnt_o(loc_gnt), .loc_rdata_o(loc_rdata),
    .reg_en_o(reg_en), .reg_we_o(reg_we), .reg_addr_o(reg_addr),
    .reg_wdata_o(reg_wdata), .reg_rdata_i(reg_rdata),
    .abort_cnt_o(abort_cnt)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%02h required=%02h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 17) ^ 8'h3C;
  endfunction

  // Register bank seen by the DUT: one-cycle read latency.
  logic [7:0] bank [16];
  int n_wr = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) bank[i] <= init_val(i);
      reg_rdata <= '0;
    end else if (reg_en) begin
      if (reg_we) bank[reg_addr] <= reg_wdata;
      else        reg_rdata      <= bank[reg_addr];
    end
  end

  always @(posedge clk) begin
    if (rst_n && reg_en && reg_we) n_wr <= n_wr + 1;
  end

  // Reference model: frame progress tracked as cycles elapsed since each byte.
  logic [7:0] mem_m [16];
  logic       fr_act, fr_rd, fr_dat;
  logic [3:0] fr_addr;
  logic [7:0] fr_wdata, rd_val, m_tx, m_abort, m_lrd;
  int         since, wsince;
  logic       e_rd, e_wr, e_g;

  assign e_rd = fr_act && fr_rd && (since == 1);
  assign e_wr = fr_act && !fr_rd && fr_dat && (wsince == 1);
  assign e_g  = loc_req && !(e_rd || e_wr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem_m[i] <= init_val(i);
      fr_act <= 1'b0; fr_rd <= 1'b0; fr_dat <= 1'b0;
      fr_addr <= '0; fr_wdata <= '0; rd_val <= '0;
      m_tx <= SYNC; m_abort <= '0; m_lrd <= '0;
      since <= 0; wsince <= 0;
    end else begin
      if (e_wr) mem_m[fr_addr] <= fr_wdata;
      if (e_rd) rd_val <= mem_m[fr_addr];
      if (e_g && loc_we)  mem_m[loc_addr] <= loc_wdata;
      if (e_g && !loc_we) m_lrd <= mem_m[loc_addr];
      if (frame_end) begin
        if (fr_act && ((fr_rd && since <= 2) || (!fr_rd && !fr_dat)) && m_abort != 8'hFF)
          m_abort <= m_abort + 8'd1;
        m_tx   <= SYNC;
        fr_act <= 1'b0;
        fr_dat <= 1'b0;
      end else begin
        if (fr_act && fr_rd && since == 2) m_tx <= rd_val;
        if (fr_act && since < 15) since <= since + 1;
        if (fr_dat && wsince < 15) wsince <= wsince + 1;
        if (rx_valid && !fr_act) begin
          fr_act  <= 1'b1;
          fr_rd   <= rx_byte[7];
          fr_addr <= rx_byte[3:0];
          since   <= 1;
        end else if (rx_valid && !fr_rd && !fr_dat) begin
          fr_dat   <= 1'b1;
          fr_wdata <= rx_byte;
          wsince   <= 1;
        end
      end
    end
  end

  // Every-cycle compare of DUT outputs against the model.
  logic gnt_seen = 1'b0;
  always @(negedge clk) begin
    chk("tx_byte", tx_byte, m_tx);
    chk("abort_cnt", abort_cnt, m_abort);
    chk("loc_rdata", loc_rdata, m_lrd);
    chk1("loc_gnt", loc_gnt, e_g);
    chk1("reg_en", reg_en, e_rd || e_wr || e_g);
    if (e_rd || e_wr || e_g) begin
      chk1("reg_we", reg_we, e_wr || (e_g && loc_we));
      chk("reg_addr", 8'(reg_addr), (e_rd || e_wr) ? 8'(fr_addr) : 8'(loc_addr));
      if (e_wr || (e_g && loc_we))
        chk("reg_wdata", reg_wdata, e_wr ? fr_wdata : loc_wdata);
    end
    gnt_seen <= loc_gnt;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic gap(input int n);
    repeat (n) tick;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick;
    rx_valid = 1'b0;
  endtask

  task automatic end_frame;
    frame_end = 1'b1;
    tick;
    frame_end = 1'b0;
  endtask

  int w0;
  int wait_c, nb, tgt;

  initial begin
    tick; tick;
    @(negedge clk);
    chk("rst_tx", tx_byte, 8'hA5);
    chk("rst_abort", abort_cnt, 8'h00);
    chk1("rst_reg_en", reg_en, 1'b0);
    tick;
    rst_n = 1'b1;
    tick;

    // Write frame
    w0 = n_wr;
    send_byte(8'h03); gap(4); send_byte(8'h5C); gap(4); end_frame; gap(1);
    chk("wr_bank3", bank[3], 8'h5C);
    chk("wr_count", 8'(n_wr - w0), 8'd1);
    chk("wr_abort", abort_cnt, 8'h00);

    // Local write of reg 7, then SPI read of it
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = 4'd7; loc_wdata = 8'hE1;
    tick;
    loc_req = 1'b0;
    gap(2);
    chk("loc_wr_bank7", bank[7], 8'hE1);
    rx_valid = 1'b1; rx_byte = 8'h87;
    @(negedge clk);
    chk("rd_tx_cmd", tx_byte, 8'hA5);
    tick;
    rx_valid = 1'b0;
    tick; tick;
    @(negedge clk);
    chk("rd_tx_data", tx_byte, 8'hE1);
    tick; gap(2);
    send_byte(8'h00); gap(4); end_frame;
    @(negedge clk);
    chk("rd_tx_after", tx_byte, 8'hA5);
    tick;

    // Contention: local read of reg 2 raised in the SPI read-access cycle
    rx_valid = 1'b1; rx_byte = 8'h82;
    tick;
    rx_valid = 1'b0;
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 4'd2;
    @(negedge clk);
    chk1("ct_gnt_blocked", loc_gnt, 1'b0);
    chk1("ct_spi_en", reg_en, 1'b1);
    chk1("ct_spi_we", reg_we, 1'b0);
    tick;
    @(negedge clk);
    chk1("ct_gnt_next", loc_gnt, 1'b1);
    chk("ct_gnt_addr", 8'(reg_addr), 8'd2);
    tick;
    loc_req = 1'b0;
    @(negedge clk);
    chk("ct_loc_rdata", loc_rdata, 8'h1E);
    chk("ct_tx", tx_byte, 8'h1E);
    tick;
    send_byte(8'h00); gap(4); end_frame; gap(1);

    // Abort: command byte only
    w0 = n_wr;
    send_byte(8'h01); gap(4); end_frame;
    @(negedge clk);
    chk("ab_abort", abort_cnt, 8'h01);
    chk("ab_tx", tx_byte, 8'hA5);
    chk("ab_nowrite", 8'(n_wr - w0), 8'd0);
    tick;

    // Extra bytes after the data byte
    w0 = n_wr;
    send_byte(8'h02); gap(4); send_byte(8'h11); gap(4);
    send_byte(8'h22); gap(4); send_byte(8'h33); gap(4); end_frame; gap(1);
    chk("ex_count", 8'(n_wr - w0), 8'd1);
    chk("ex_bank2", bank[2], 8'h11);

    // Reset while waiting for write data
    send_byte(8'h04); gap(2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_tx", tx_byte, 8'hA5);
    chk("mr_abort", abort_cnt, 8'h00);
    chk("mr_loc_rdata", loc_rdata, 8'h00);
    chk1("mr_reg_en", reg_en, 1'b0);
    tick;
    rst_n = 1'b1;
    tick;
    w0 = n_wr;
    send_byte(8'h05); gap(4); send_byte(8'h77); gap(4); end_frame; gap(1);
    chk("mr_bank5", bank[5], 8'h77);
    chk("mr_count", 8'(n_wr - w0), 8'd1);

    // Randomized frames and local traffic
    wait_c = 0; nb = 0; tgt = 2;
    for (int c = 0; c < 4000; c++) begin
      rx_valid  = 1'b0;
      frame_end = 1'b0;
      if (wait_c > 0) begin
        wait_c--;
      end else if (nb < tgt) begin
        rx_valid = 1'b1;
        rx_byte  = 8'($urandom);
        nb++;
        wait_c = $urandom_range(3, 7);
        if ($urandom_range(0, 9) == 0) begin
          frame_end = 1'b1;
          nb  = 0;
          tgt = $urandom_range(0, 4);
        end
      end else begin
        frame_end = 1'b1;
        nb     = 0;
        tgt    = $urandom_range(0, 4);
        wait_c = $urandom_range(0, 3);
      end
      if (loc_req && gnt_seen) begin
        loc_req = ($urandom_range(0, 2) == 0);
        loc_we = 1'($urandom_range(0, 1)); loc_addr = 4'($urandom_range(0, 15));
        loc_wdata = 8'($urandom);
      end else if (!loc_req && $urandom_range(0, 3) == 0) begin
        loc_req = 1'b1;
        loc_we = 1'($urandom_range(0, 1)); loc_addr = 4'($urandom_range(0, 15));
        loc_wdata = 8'($urandom);
      end
      tick;
    end
    loc_req = 1'b0; rx_valid = 1'b0; frame_end = 1'b0;
    gap(2);
    end_frame; gap(1);

    // Saturation of the abort counter
    repeat (260) begin
      send_byte(8'h01); gap(1); end_frame;
    end
    gap(1);
    chk("sat_abort", abort_cnt, 8'hFF);
    send_byte(8'h09); gap(1); end_frame; gap(1);
    chk("sat_hold", abort_cnt, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
